// File: rtl/daq_pkg.sv
// Shared constants for the switch sampler: register map, CTRL/STATUS bit
// positions and the bus request bundle.
package daq_pkg;

  localparam int TS_W = 16;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_DATA   = 3'd2;
  localparam logic [2:0] ADDR_DIV    = 3'd3;
  localparam logic [2:0] ADDR_LED    = 3'd4;
  localparam logic [2:0] ADDR_TS     = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } avs_req_t;

endpackage

// File: rtl/daq_sync_fifo.sv
// Single-clock FIFO. A pop in the same cycle frees a slot for a push when full;
// the synchronous clear overrides both.
module daq_sync_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 16
) (
  input  logic                       gclk,
  input  logic                       grst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge gclk) begin
    if (!grst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge gclk) begin
    if (grst_n && !clr && push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/daq_sw_sampler_slave.sv
// Avalon-MM responder: periodic timestamped switch sampling into a FIFO that
// the host drains by register reads, plus a writable LED register.
module daq_sw_sampler_slave
  import daq_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] led_out,
  output logic              irq
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = TS_W + DATA_W;

  avs_req_t req;
  assign req = '{rd: avs_read, wr: avs_write, addr: avs_address, wdata: avs_writedata};

  logic [DATA_W-1:0] sw_meta, sw_sync;
  logic              en, irq_en, ovf;
  logic [DIV_W-1:0]  div, pre;
  logic [TS_W-1:0]   ts;

  logic              wr_ctrl, wr_status, clr, tick, pop_req, ovf_set;
  logic              f_full, f_empty;
  logic [AW:0]       f_count;
  logic [ENT_W-1:0]  f_head;
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  assign unused_wdata = ^avs_writedata;

  assign wr_ctrl   = req.wr && (req.addr == ADDR_CTRL);
  assign wr_status = req.wr && (req.addr == ADDR_STATUS);
  assign clr       = wr_ctrl && req.wdata[CTRL_CLR];
  assign tick      = en && (pre == div);
  assign pop_req   = req.rd && (req.addr == ADDR_DATA);
  // A same-cycle pop makes room, so a full FIFO only overflows without one.
  assign ovf_set   = tick && f_full && !pop_req;

  daq_sync_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .gclk   (clk_clk),
    .grst_n (reset_reset_n),
    .clr    (clr),
    .push   (tick),
    .din    ({ts, sw_sync}),
    .pop    (pop_req),
    .dout   (f_head),
    .full   (f_full),
    .empty  (f_empty),
    .count  (f_count)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      div     <= '0;
      led_out <= '0;
    end else if (req.wr) begin
      case (req.addr)
        ADDR_CTRL: begin
          en     <= req.wdata[CTRL_EN];
          irq_en <= req.wdata[CTRL_IRQ_EN];
        end
        ADDR_DIV: div     <= req.wdata[DIV_W-1:0];
        ADDR_LED: led_out <= req.wdata[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || clr) begin
      ts  <= '0;
      pre <= '0;
      ovf <= 1'b0;
    end else begin
      if (en) ts <= ts + 1'b1;
      if (!en || tick) pre <= '0;
      else             pre <= pre + 1'b1;
      if (ovf_set)                             ovf <= 1'b1;
      else if (wr_status && req.wdata[ST_OVF]) ovf <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (req.addr)
      ADDR_CTRL:   rd_mux = {30'd0, irq_en, en};
      ADDR_STATUS: begin
        rd_mux[7:0]      = 8'(f_count);
        rd_mux[ST_EMPTY] = f_empty;
        rd_mux[ST_FULL]  = f_full;
        rd_mux[ST_OVF]   = ovf;
      end
      ADDR_DATA:   if (!f_empty)
                     rd_mux = 32'({f_head[ENT_W-1:DATA_W], {(16-DATA_W){1'b0}},
                                  f_head[DATA_W-1:0]});
      ADDR_DIV:    rd_mux = 32'(div);
      ADDR_LED:    rd_mux = 32'(led_out);
      ADDR_TS:     rd_mux = 32'(ts);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      irq               <= 1'b0;
    end else begin
      avs_readdata      <= req.rd ? rd_mux : '0;
      avs_readdatavalid <= req.rd;
      irq               <= irq_en & ~f_empty;
    end
  end

endmodule

// File: tb/tb_daq_sw_sampler_slave.sv
// Randomized bench for daq_sw_sampler_slave against a queue-based register model.
module tb_daq_sw_sampler_slave;
  localparam int DEPTH = 16;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [2:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [3:0]  sw_in;
  logic [3:0]  led_out;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [31:0] m_q[$];
  int          m_ts, m_pre, m_div;
  logic        m_en, m_irqen, m_ovf;
  logic [3:0]  m_led, m_s1, m_s2;

  daq_sw_sampler_slave dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .sw_in             (sw_in),
    .led_out           (led_out),
    .irq               (irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ts = 0; m_pre = 0; m_div = 0;
    m_en = 0; m_irqen = 0; m_ovf = 0;
    m_led = 0; m_s1 = 0; m_s2 = 0;
  endtask

  // One bus cycle, driven from the falling edge, checked 1 time unit after the rising edge.
  task automatic bus(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic        exp_irq, tick, clr, pop, oset;
    logic [3:0]  smp;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;

    exp_rd = 0;
    case (a)
      3'd0: exp_rd = {30'd0, m_irqen, m_en};
      3'd1: begin
        exp_rd[7:0] = 8'(m_q.size());
        exp_rd[8]   = (m_q.size() == 0);
        exp_rd[9]   = (m_q.size() == DEPTH);
        exp_rd[10]  = m_ovf;
      end
      3'd2: exp_rd = (m_q.size() != 0) ? m_q[0] : 32'd0;
      3'd3: exp_rd = 32'(m_div);
      3'd4: exp_rd = 32'(m_led);
      3'd5: exp_rd = 32'(m_ts);
      default: exp_rd = 0;
    endcase
    exp_irq = m_irqen && (m_q.size() != 0);

    tick = m_en && (m_pre == m_div);
    smp  = m_s2;
    clr  = wr && (a == 3'd0) && wd[2];
    pop  = rd && (a == 3'd2) && (m_q.size() != 0);
    oset = 0;
    if (clr) begin
      m_q.delete(); m_ts = 0; m_pre = 0; m_ovf = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (tick) begin
        if (m_q.size() < DEPTH) m_q.push_back({m_ts[15:0], 12'h000, smp});
        else oset = 1;
      end
      if (oset) m_ovf = 1;
      else if (wr && a == 3'd1 && wd[10]) m_ovf = 0;
      if (m_en) m_ts = (m_ts + 1) & 16'hFFFF;
      m_pre = (!m_en || m_pre == m_div) ? 0 : m_pre + 1;
    end
    if (wr) begin
      if (a == 3'd0) begin m_en = wd[0]; m_irqen = wd[1]; end
      if (a == 3'd3) m_div = int'(wd[15:0]);
      if (a == 3'd4) m_led = wd[3:0];
    end
    m_s2 = m_s1; m_s1 = sw_in;

    @(posedge clk_clk); #1;
    chk("rvalid", 32'(avs_readdatavalid), 32'(rd));
    if (rd) chk($sformatf("rdata_a%0d", a), avs_readdata, exp_rd);
    chk("irq", 32'(irq), 32'(exp_irq));
    chk("led", 32'(led_out), 32'(m_led));
    @(negedge clk_clk);
  endtask

  task automatic rst_cycle(input logic rd);
    reset_reset_n = 0; avs_read = rd; avs_write = 0; avs_address = 3'd2; avs_writedata = 0;
    @(posedge clk_clk); #1;
    chk("rst_rvalid", 32'(avs_readdatavalid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    model_reset();
    @(negedge clk_clk);
    reset_reset_n = 1; avs_read = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(0, 0, 3'd0, 32'd0);
  endtask

  initial begin
    reset_reset_n = 0; avs_read = 0; avs_write = 0; avs_address = 0; avs_writedata = 0;
    sw_in = 0;
    model_reset();
    @(negedge clk_clk);
    rst_cycle(0);
    rst_cycle(0);

    for (int a = 0; a < 8; a++) bus(1, 0, 3'(a), 32'd0);

    bus(0, 1, 3'd4, 32'hA);
    bus(1, 0, 3'd4, 32'd0);

    sw_in = 4'h5;
    bus(0, 1, 3'd3, 32'd3);
    bus(0, 1, 3'd0, 32'd1);
    idle(20);
    bus(1, 0, 3'd1, 32'd0);
    for (int i = 0; i < 6; i++) bus(1, 0, 3'd2, 32'd0);

    bus(0, 1, 3'd3, 32'd0);
    idle(40);
    bus(1, 0, 3'd1, 32'd0);
    bus(1, 0, 3'd2, 32'd0);
    bus(0, 1, 3'd1, 32'h400);
    bus(1, 0, 3'd1, 32'd0);
    for (int i = 0; i < 20; i++) bus(1, 0, 3'd2, 32'd0);
    bus(1, 0, 3'd1, 32'd0);

    bus(0, 1, 3'd0, 32'd0);
    bus(0, 1, 3'd0, 32'd2);
    idle(3);
    bus(0, 1, 3'd0, 32'd3);
    idle(4);
    bus(0, 1, 3'd0, 32'd7);
    bus(1, 0, 3'd1, 32'd0);
    bus(1, 0, 3'd5, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int op;
      logic [2:0] a;
      logic [31:0] wd;
      if ($urandom_range(0, 15) == 0) sw_in = 4'($urandom_range(0, 15));
      op = $urandom_range(0, 9);
      a  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = 3'd2;
      wd = $urandom;
      if (a == 3'd0) wd = {29'd0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 4) != 0)};
      if (a == 3'd3) wd = 32'($urandom_range(0, 4));
      if (op < 4)      bus(0, 0, a, wd);
      else if (op < 8) bus(1, 0, a, wd);
      else if (op < 9) bus(0, 1, a, wd);
      else             bus(1, 1, a, wd);
    end

    bus(0, 1, 3'd3, 32'd0);
    bus(0, 1, 3'd0, 32'd3);
    idle(6);
    bus(1, 0, 3'd2, 32'd0);
    avs_read = 1; avs_address = 3'd2;
    rst_cycle(1);
    bus(1, 0, 3'd1, 32'd0);
    bus(1, 0, 3'd2, 32'd0);
    bus(1, 0, 3'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/daq_sw_sampler_slave.md
Name: daq_sw_sampler_slave

Overview:
- Avalon-MM responder (slave) hung off the HPS lightweight H2F bridge. Same fabric side as the HPS master that drives the LED/SW PIOs.
- Periodically samples the 4-bit switch bus and tags each sample with a 16-bit timestamp. Tagged samples are buffered in a FIFO that the HPS drains by register reads.
- Also drives the LED bus from a writable register.
- Replaces the plain SW PIO for acquisition use.

Parameters:
- DATA_W, 4, width of sampled input bus and LED output bus.
- FIFO_DEPTH, 16, sample FIFO entries (power of two, ≥2).
- DIV_W, 16, width of sample-rate divider.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  synchronous active-low reset.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid when avs_readdatavalid=1.
- avs_readdatavalid  out  1  read response strobe.
- sw_in  in  DATA_W  asynchronous switch inputs.
- led_out  out  DATA_W  LED drive.
- irq  out  1  level interrupt: FIFO non-empty and irq_en=1.

Behaviour:
- Reset (reset_reset_n=0 sampled at clk edge):
  - All regs 0: ctrl, divider (DIV_W'd0), led_out, FIFO pointers/count, overflow flag, timestamp, prescale counter.
  - avs_readdata=0, avs_readdatavalid=0, irq=0.
  - Reset mid-operation discards FIFO contents and any pending read response.
- Input synchronisation: sw_in passes through a 2-flop synchroniser. The sample taken is the second flop.
- Register map (word addresses):
  - 0 CTRL RW: bit0 enable, bit1 irq_en, bit2 clear (write-1 self-clearing pulse, reads 0).
  - 1 STATUS RO: [7:0] fill level, bit8 empty, bit9 full, bit10 overflow (sticky). Writing 1 to bit10 clears overflow.
  - 2 DATA RO-pop: {timestamp[15:0], 12'b0, sample[DATA_W-1:0]} zero-padded to 32 bits. A read pops one entry.
  - 3 DIVIDER RW [DIV_W-1:0].
  - 4 LED RW [DATA_W-1:0], drives led_out directly.
  - 5 TIMESTAMP RO, live counter.
  - 6–7 read 0, writes ignored.
- Read latency: fixed 1.
  - avs_readdatavalid=1 exactly one cycle after each avs_read. No waitrequest.
  - avs_read and avs_write asserted together: write takes effect, read returns pre-write value.
- Timestamp: 16-bit free-running counter, increments every clock while enable=1. Wraps 0xFFFF→0. Cleared by clear.
- Sample tick:
  - Prescaler counts 0..DIVIDER while enable=1. Tick when count==DIVIDER, then the counter returns to 0.
  - DIVIDER=0 gives a tick every cycle.
  - enable=0 holds the prescaler at 0 and produces no ticks.
- Push on tick:
  - If not full, write {timestamp, sample} and count+1.
  - If full, drop the new sample and set overflow. Old data is kept.
- Pop: read of address 2 when not empty. readdata is the head entry, and the head advances.
  - Read of address 2 when empty returns 0 and does not move pointers.
- Simultaneous push and pop in one cycle:
  - Both occur and count is unchanged.
  - When full, the pop frees the slot, so the push succeeds with no overflow.
- Clear pulse: empties the FIFO, zeroes timestamp and prescaler, clears overflow. Clear wins over a same-cycle push or pop.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- irq: registered, equals irq_en & ~empty, one cycle after state change.

Decomposition:
- Package daq_pkg holds:
  - register address localparams: ADDR_CTRL=0, ADDR_STATUS=1, ADDR_DATA=2, ADDR_DIV=3, ADDR_LED=4, ADDR_TS=5;
  - CTRL/STATUS bit indices;
  - TS_W=16.
- One sub-module, daq_sync_fifo: single-clock FIFO with push, pop, full, empty and count.
  - Pop-before-push semantics when full.
  - Same synchronous active-low reset plus a synchronous clear input.

Test Plan:
- Reset then read addresses 0–5 → all return 0. readdatavalid pulses exactly 1 cycle after each read. led_out=0, irq=0.
- Write LED=0xA, read back → led_out=4'hA next cycle, readdata=0xA.
- sw_in=0x5, DIVIDER=3, enable=1, wait 20 cycles → STATUS level=5. DATA reads return sample 0x5 with timestamps differing by 4.
- DIVIDER=0, enable, no reads for 40 cycles → level=16, full=1, overflow=1. First DATA read returns the earliest timestamp. Write STATUS bit10=1 → overflow=0.
- FIFO full, DIVIDER=0, continuous DATA reads → level stays 16 and overflow does not re-set after being cleared.
- Enable with irq_en=1 → irq rises after the first sample. Write CTRL clear=1 → level=0, TIMESTAMP reads near 0, irq drops next cycle. Assert reset_reset_n=0 mid-stream → FIFO empty and pending readdatavalid suppressed.
